// File: rtl/ps2_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_rx : PS/2 device-to-host receiver with show-ahead byte FIFO      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  logic       clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
  logic       fall;
  logic [0:0] state, state_nxt;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic [TW-1:0] timer;
  logic       timeout;
  logic       stop_edge, push_req, perr_nxt, ferr_nxt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, wr_en;

  // clk_s3 holds the previous synced clock for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1; clk_s3 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;  clk_s2 <= clk_s1; clk_s3 <= clk_s2;
      dat_s1 <= ps2_data; dat_s2 <= dat_s1;
    end
  end

  assign fall    = clk_s3 & ~clk_s2;
  assign timeout = (state == S_RECV) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (fall && !dat_s2) state_nxt = S_RECV;
      S_RECV: if (timeout || (fall && bit_cnt == 4'd9)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stop_edge = (state == S_RECV) && fall && (bit_cnt == 4'd9);
    push_req  = stop_edge && dat_s2 && (^{shreg, par_bit});
    perr_nxt  = stop_edge && dat_s2 && !(^{shreg, par_bit});
    ferr_nxt  = (stop_edge && !dat_s2) || timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 4'd0;
      timer   <= '0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
    end else if (state == S_IDLE) begin
      bit_cnt <= 4'd0;
      timer   <= '0;
    end else if (fall) begin
      timer   <= '0;
      bit_cnt <= bit_cnt + 4'd1;
      if (bit_cnt < 4'd8)  shreg   <= {dat_s2, shreg[7:1]};
      if (bit_cnt == 4'd8) par_bit <= dat_s2;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  assign full  = (count == CW'(FIFO_DEPTH));
  assign valid = (count != '0);
  assign pop   = valid & ready;
  // When full, a simultaneous pop frees the head slot that wr_ptr aliases
  assign wr_en = push_req & (!full | pop);
  assign data  = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      err_parity <= perr_nxt;
      err_frame  <= ferr_nxt;
      overflow   <= push_req & full & !pop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_rx : directed self-checking bench for ps2_rx                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ps2_rx;

  localparam int TIMEOUT = 500;
  localparam int HALF    = 8;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, ready;
  logic [7:0] data;
  logic       valid, err_parity, err_frame, overflow;

  int vectors = 0;
  int miscompares = 0;
  int n_perr = 0, n_ferr = 0, n_ovf = 0;
  logic [7:0] popq[$];

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .valid(valid), .ready(ready),
    .err_parity(err_parity), .err_frame(err_frame), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_parity) n_perr++;
    if (err_frame)  n_ferr++;
    if (overflow)   n_ovf++;
    if (valid && ready) popq.push_back(data);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, logic flip, logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~(^d) ^ flip);
    send_bit(stop);
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic test_reset;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ready = 1'b0;
    tick(5);
    @(negedge clk);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", valid); end
    vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL rst_data got %h exp 00", data); end
    vectors++; if (err_parity !== 1'b0) begin miscompares++; $display("FAIL rst_perr got %b exp 0", err_parity); end
    vectors++; if (err_frame !== 1'b0) begin miscompares++; $display("FAIL rst_ferr got %b exp 0", err_frame); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_good_frame;
    int p0 = n_perr, f0 = n_ferr;
    logic [7:0] d = 8'h1C;
    ready = 1'b1;
    popq.delete();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;           // stop edge: 2 sync cycles, detect, then push
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL good_early_valid got %b exp 0", valid); end
    @(posedge clk); @(negedge clk);
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL good_valid got %b exp 1", valid); end
    vectors++; if (data !== 8'h1C) begin miscompares++; $display("FAIL good_data got %h exp 1c", data); end
    @(negedge clk);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL good_valid_1cyc got %b exp 0", valid); end
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF);
    vectors++; if (popq.size() !== 1) begin miscompares++; $display("FAIL good_popcnt got %0d exp 1", popq.size()); end
    vectors++; if ((n_perr - p0) !== 0 || (n_ferr - f0) !== 0)
      begin miscompares++; $display("FAIL good_noerr got perr=%0d ferr=%0d exp 0 0", n_perr - p0, n_ferr - f0); end
  endtask

  task automatic test_errors;
    int p0 = n_perr, f0 = n_ferr;
    popq.delete();
    send_frame(8'h1C, 1'b1, 1'b1);
    tick(10);
    vectors++; if ((n_perr - p0) !== 1) begin miscompares++; $display("FAIL parity_pulse got %0d exp 1", n_perr - p0); end
    vectors++; if ((n_ferr - f0) !== 0) begin miscompares++; $display("FAIL parity_noframe got %0d exp 0", n_ferr - f0); end
    p0 = n_perr; f0 = n_ferr;
    send_frame(8'hF0, 1'b0, 1'b0);
    tick(10);
    vectors++; if ((n_ferr - f0) !== 1) begin miscompares++; $display("FAIL frame_pulse got %0d exp 1", n_ferr - f0); end
    vectors++; if ((n_perr - p0) !== 0) begin miscompares++; $display("FAIL frame_noparity got %0d exp 0", n_perr - p0); end
    vectors++; if (popq.size() !== 0 || valid !== 1'b0)
      begin miscompares++; $display("FAIL err_nobyte got pops=%0d valid=%b exp 0 0", popq.size(), valid); end
  endtask

  task automatic test_overflow;
    int o0 = n_ovf;
    logic [7:0] exp;
    ready = 1'b0;
    popq.delete();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1);
    tick(5);
    vectors++; if ((n_ovf - o0) !== 0) begin miscompares++; $display("FAIL ovf_early got %0d exp 0", n_ovf - o0); end
    vectors++; if (valid !== 1'b1 || data !== 8'h01)
      begin miscompares++; $display("FAIL ovf_head got valid=%b data=%h exp 1 01", valid, data); end
    send_frame(8'h05, 1'b0, 1'b1);
    tick(5);
    vectors++; if ((n_ovf - o0) !== 1) begin miscompares++; $display("FAIL ovf_pulse got %0d exp 1", n_ovf - o0); end
    ready = 1'b1;
    tick(10);
    vectors++; if (popq.size() !== 4) begin miscompares++; $display("FAIL ovf_drain_cnt got %0d exp 4", popq.size()); end
    for (int i = 0; i < 4 && i < popq.size(); i++) begin
      exp = 8'(i + 1);
      vectors++; if (popq[i] !== exp) begin miscompares++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, popq[i], exp); end
    end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %b exp 0", valid); end
  endtask

  task automatic test_timeout;
    int f0 = n_ferr;
    ready = 1'b1;
    popq.delete();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    ps2_data = 1'b1;
    tick(TIMEOUT - 4 * HALF);
    vectors++; if ((n_ferr - f0) !== 0) begin miscompares++; $display("FAIL tmo_early got %0d exp 0", n_ferr - f0); end
    tick(4 * HALF + 50);
    vectors++; if ((n_ferr - f0) !== 1) begin miscompares++; $display("FAIL tmo_pulse got %0d exp 1", n_ferr - f0); end
    send_frame(8'h5A, 1'b0, 1'b1);
    tick(10);
    vectors++; if (popq.size() !== 1 || (popq.size() == 1 && popq[0] !== 8'h5A))
      begin miscompares++; $display("FAIL tmo_recover got n=%0d first=%h exp 1 5a", popq.size(), (popq.size() > 0) ? popq[0] : 8'hxx); end
    vectors++; if ((n_ferr - f0) !== 1) begin miscompares++; $display("FAIL tmo_once got %0d exp 1", n_ferr - f0); end
  endtask

  task automatic test_reset_midframe;
    int p0 = n_perr, f0 = n_ferr;
    ready = 1'b1;
    popq.delete();
    for (int i = 0; i < 5; i++) send_bit(1'b0);   // start + low nibble of 0xF0
    rst = 1'b1;
    tick(3);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b exp 0", valid); end
    rst = 1'b0;
    tick(5);
    for (int i = 0; i < 6; i++) send_bit(1'b1);   // high nibble, parity 1, stop 1
    tick(20);
    vectors++; if (popq.size() !== 0) begin miscompares++; $display("FAIL mid_leftover got %0d exp 0", popq.size()); end
    vectors++; if ((n_perr - p0) !== 0 || (n_ferr - f0) !== 0)
      begin miscompares++; $display("FAIL mid_noerr got perr=%0d ferr=%0d exp 0 0", n_perr - p0, n_ferr - f0); end
    send_frame(8'h29, 1'b0, 1'b1);
    tick(10);
    vectors++; if (popq.size() !== 1 || (popq.size() == 1 && popq[0] !== 8'h29))
      begin miscompares++; $display("FAIL mid_next got n=%0d first=%h exp 1 29", popq.size(), (popq.size() > 0) ? popq[0] : 8'hxx); end
  endtask

  task automatic test_back_to_back;
    int o0 = n_ovf;
    logic [7:0] d = 8'hA5;
    logic [7:0] exp;
    ready = 1'b0;
    popq.delete();
    for (int i = 1; i <= 4; i++) send_frame(8'hA0 + 8'(i), 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~(^d));
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    ready = 1'b1;             // first pop lands on the push edge
    @(posedge clk); @(negedge clk);
    vectors++; if (valid !== 1'b1 || data !== 8'hA2)
      begin miscompares++; $display("FAIL b2b_head got valid=%b data=%h exp 1 a2", valid, data); end
    tick(HALF);
    ps2_clk = 1'b1;
    tick(20);
    vectors++; if ((n_ovf - o0) !== 0) begin miscompares++; $display("FAIL b2b_ovf got %0d exp 0", n_ovf - o0); end
    vectors++; if (popq.size() !== 5) begin miscompares++; $display("FAIL b2b_cnt got %0d exp 5", popq.size()); end
    for (int i = 0; i < 5 && i < popq.size(); i++) begin
      exp = 8'hA1 + 8'(i);
      vectors++; if (popq[i] !== exp) begin miscompares++; $display("FAIL b2b_order[%0d] got %h exp %h", i, popq[i], exp); end
    end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_errors;
    test_overflow;
    test_timeout;
    test_reset_midframe;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
- REQ-001: The block SHALL have parameter TIMEOUT_CYCLES, default 200000, meaning the maximum clk cycles allowed between PS/2 clock falling edges inside a frame (2 ms at 100 MHz).
- REQ-002: The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of received bytes buffered (power of two, at least 2).
- REQ-003: Port clk, input, 1 bit: system clock; every flop SHALL be clocked on its rising edge; this is the block's only clock.
- REQ-004: Port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-005: Port ps2_clk, input, 1 bit: raw PS/2 clock from the pin, asynchronous to clk.
- REQ-006: Port ps2_data, input, 1 bit: raw PS/2 data from the pin, asynchronous to clk.
- REQ-007: Port data, output, 8 bits: oldest buffered scan-code byte.
- REQ-008: Port valid, output, 1 bit: data holds a byte.
- REQ-009: Port ready, input, 1 bit: consumer accepts the byte.
- REQ-010: Port err_parity, output, 1 bit: one-cycle pulse on a parity failure.
- REQ-011: Port err_frame, output, 1 bit: one-cycle pulse on a bad stop bit or a timeout.
- REQ-012: Port overflow, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
- REQ-013: ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; both sync flops reset to 1.
- REQ-014: A falling edge SHALL be detected in the cycle where the previous synced ps2_clk is 1 and the current one is 0; synced ps2_data SHALL be sampled in that same cycle.
- REQ-015: The FSM SHALL have states IDLE and RECV, with a 4-bit bit counter covering 8 data bits, parity and stop.
- REQ-016: In IDLE, an edge with sampled data 0 (start bit) SHALL move to RECV with the bit counter at 0; an edge with sampled data 1 SHALL leave the FSM in IDLE with no error.
- REQ-017: In RECV, the first 8 edges SHALL shift data in LSB first, the 9th edge SHALL capture parity, and the 10th edge SHALL capture stop and return to IDLE.
- REQ-018: On the stop edge, if stop=1 and the nine data+parity bits have odd parity, the byte SHALL be pushed to the FIFO.
- REQ-019: If stop=0, err_frame SHALL pulse and the byte SHALL be discarded; if stop=1 and parity is bad, err_parity SHALL pulse and the byte SHALL be discarded; err_frame takes priority, and the two never pulse together.
- REQ-020: Timeout counter:
  - cleared on entering RECV and on every edge in RECV;
  - on reaching TIMEOUT_CYCLES, FSM returns to IDLE, partial byte is discarded, err_frame pulses once.
- REQ-021: Latency: a byte pushed in the stop-edge cycle N SHALL give valid=1 with the correct data in cycle N+1 when the FIFO was empty.
- REQ-022: FIFO behaviour:
  - show-ahead: data = head entry whenever valid=1;
  - valid = (count != 0);
  - pop when valid & ready;
  - data and valid SHALL hold stable while valid & !ready.
- REQ-023: A push and a pop in the same cycle SHALL both occur (count unchanged), even when the FIFO is full.
- REQ-024: A push while full with no pop SHALL drop the new byte, pulse overflow, and leave the stored contents unchanged.
- REQ-025: Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
- REQ-026: ready while valid=0 SHALL have no effect.

Reset
- REQ-027: While rst=1 at a clk edge, the block SHALL:
  - enter IDLE;
  - clear the bit counter, timeout counter, FIFO pointers and count;
  - set valid=0, err_parity=0, err_frame=0, overflow=0, data=0x00;
  - set the sync flops to 1.
- REQ-028: A reset mid-frame SHALL discard the partial frame with no error pulse; edges arriving after release SHALL start a new frame only on a valid start bit.

Verification
- REQ-029: Frame 0x1C with parity 0 and stop 1, ready=1 -> valid high for exactly 1 cycle with data=0x1C, one cycle after the stop edge; no error pulses.
- REQ-030: Frame 0x1C with parity 1 -> err_parity pulses once, valid stays 0; frame 0xF0 with stop=0 -> err_frame pulses once, valid stays 0.
- REQ-031: ready=0, send 5 good frames 0x01..0x05 (depth 4) -> overflow pulses once on the 5th; then ready=1 -> drains 0x01,0x02,0x03,0x04 in order, after which valid=0.
- REQ-032: Start bit plus 4 data bits, then ps2_clk idle for TIMEOUT_CYCLES -> err_frame pulses once; a following good frame 0x5A is received correctly.
- REQ-033: rst asserted after the 5th bit of a frame -> valid=0 and no error pulses; after release, the remaining edges of the old frame produce no output, and the next full frame 0x29 yields data=0x29.
- REQ-034: FIFO full with ready=1 held while a new good frame completes -> push and pop in the same cycle, no overflow, byte order preserved.
